// File: rtl/mux_scan_sel.sv
// mux_scan_sel
//   Parametrised NCH-channel, DW-bit registered multiplexer with a valid/ready
//   output stream. A run-time enable mask zeroes dead channels. Two modes:
//     direct (iMode=0): each output word comes from channel iSelect.
//     scan   (iMode=1): round-robin over enabled channels, DWELL words each.
//
// Ports
//   iClk     in   1        clock, rising edge
//   iRst_n   in   1        asynchronous active-low reset (release is expected
//                          to be synchronised to iClk by the reset tree)
//   iData    in   NCH*DW   channel k occupies iData[k*DW +: DW]
//   iEnMask  in   NCH      1 = channel enabled; disabled channels read as 0
//   iSelect  in   SELW     channel index used in direct mode
//   iMode    in   1        0 = direct, 1 = scan
//   iReady   in   1        downstream accepts oData this cycle
//   oData    out  DW       registered sample
//   oChan    out  SELW     channel index oData came from
//   oValid   out  1        oData/oChan valid

module mux_scan_sel #(
    parameter int NCH   = 8,
    parameter int DW    = 1,
    parameter int SELW  = $clog2(NCH),
    parameter int DWELL = 4
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic [NCH*DW-1:0] iData,
    input  logic [NCH-1:0]    iEnMask,
    input  logic [SELW-1:0]   iSelect,
    input  logic              iMode,
    input  logic              iReady,
    output logic [DW-1:0]     oData,
    output logic [SELW-1:0]   oChan,
    output logic              oValid
);

    localparam int              CNTW     = $clog2(DWELL + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

    typedef enum logic [1:0] {
        stDirect,
        stSeek,
        stScan
    } stateT;

    stateT           state, stateNext;
    logic [SELW-1:0] ptr, ptrNext;
    logic [CNTW-1:0] cnt, cntNext;
    logic [DW-1:0]   dataNext;
    logic [SELW-1:0] chanNext;
    logic            validNext;
    logic            load;

    // Sample of channel idx, or 0 when the channel is disabled or idx >= NCH.
    function automatic logic [DW-1:0] chanData(
        input logic [SELW-1:0]   idx,
        input logic [NCH*DW-1:0] data,
        input logic [NCH-1:0]    mask
    );
        logic [DW-1:0] result;
        result = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx == SELW'(k) && mask[k]) begin
                result = data[k*DW +: DW];
            end
        end
        return result;
    endfunction

    // Lowest enabled index; scanned high-to-low so the lowest match wins.
    function automatic logic [SELW-1:0] firstEnabled(input logic [NCH-1:0] mask);
        logic [SELW-1:0] result;
        result = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k]) begin
                result = SELW'(k);
            end
        end
        return result;
    endfunction

    // Next enabled index after 'from', wrapping NCH-1 -> 0. Walks the mask
    // rotated so that 'from'+1 is offset 1; offset NCH is 'from' itself, so a
    // lone enabled channel maps back onto itself.
    function automatic logic [SELW-1:0] nextEnabled(
        input logic [SELW-1:0] from,
        input logic [NCH-1:0]  mask
    );
        logic [SELW-1:0] result;
        int              idx;
        result = from;
        for (int d = NCH; d >= 1; d--) begin
            idx = (int'(from) + d) % NCH;
            if (mask[idx]) begin
                result = SELW'(idx);
            end
        end
        return result;
    endfunction

    // A new word may be written when the output slot is empty or being drained.
    assign load = !oValid || iReady;

    always_comb begin
        // NOTE: every output of this block gets a default first (hold current
        // value); a path that skips an assignment would otherwise infer a latch.
        stateNext = state;
        ptrNext   = ptr;
        cntNext   = cnt;
        dataNext  = oData;
        chanNext  = oChan;
        validNext = oValid;

        case (state)
            stDirect: begin
                if (iMode) begin
                    stateNext = stSeek;
                end else if (load) begin
                    dataNext  = chanData(iSelect, iData, iEnMask);
                    chanNext  = iSelect;
                    validNext = 1'b1;
                end
            end

            stSeek: begin
                if (!iMode) begin
                    stateNext = stDirect;
                end else if (iEnMask == '0) begin
                    // Nothing to scan: let the held word drain, then go idle.
                    if (load) begin
                        validNext = 1'b0;
                    end
                end else begin
                    ptrNext   = firstEnabled(iEnMask);
                    cntNext   = '0;
                    stateNext = stScan;
                end
            end

            stScan: begin
                if (!iMode) begin
                    stateNext = stDirect;
                end else if (!iEnMask[ptr]) begin
                    // Current channel was disabled under us: restart the search.
                    stateNext = stSeek;
                end else if (load) begin
                    dataNext  = chanData(ptr, iData, iEnMask);
                    chanNext  = ptr;
                    validNext = 1'b1;
                    if (cnt == CNT_LAST) begin
                        cntNext = '0;
                        ptrNext = nextEnabled(ptr, iEnMask);
                    end else begin
                        cntNext = cnt + 1'b1;
                    end
                end
            end

            default: begin
                stateNext = stDirect;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state  <= stDirect;
            ptr    <= '0;
            cnt    <= '0;
            oData  <= '0;
            oChan  <= '0;
            oValid <= 1'b0;
        end else begin
            state  <= stateNext;
            ptr    <= ptrNext;
            cnt    <= cntNext;
            oData  <= dataNext;
            oChan  <= chanNext;
            oValid <= validNext;
        end
    end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel (NCH=8, DW=1, DWELL=4). Inputs change 1 ns
// after a rising edge; outputs are checked 1 ns after the following edge.

module tb_mux_scan_sel;

    localparam int NCH   = 8;
    localparam int DW    = 1;
    localparam int SELW  = 3;
    localparam int DWELL = 4;

    logic              iClk = 1'b0;
    logic              iRst_n;
    logic [NCH*DW-1:0] iData;
    logic [NCH-1:0]    iEnMask;
    logic [SELW-1:0]   iSelect;
    logic              iMode;
    logic              iReady;
    logic [DW-1:0]     oData;
    logic [SELW-1:0]   oChan;
    logic              oValid;

    int checks = 0;
    int errors = 0;

    mux_scan_sel #(
        .NCH  (NCH),
        .DW   (DW),
        .SELW (SELW),
        .DWELL(DWELL)
    ) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iData  (iData),
        .iEnMask(iEnMask),
        .iSelect(iSelect),
        .iMode  (iMode),
        .iReady (iReady),
        .oData  (oData),
        .oChan  (oChan),
        .oValid (oValid)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOut(input string tag, input logic expData,
                            input int expChan, input logic expValid);
        check({tag, ".data"},  32'(oData),  32'(expData));
        check({tag, ".chan"},  32'(oChan),  32'(expChan));
        check({tag, ".valid"}, 32'(oValid), 32'(expValid));
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        logic [7:0] expDirect;
        int         scanSeq[5];

        // ---------------- reset ----------------
        iRst_n  = 1'b0;
        iData   = '0;
        iEnMask = '0;
        iSelect = '0;
        iMode   = 1'b0;
        iReady  = 1'b0;
        #12;
        checkOut("reset", 1'b0, 0, 1'b0);
        iRst_n = 1'b1;

        // ---------------- 1: direct sweep ----------------
        iEnMask   = 8'h27;
        iData     = 8'hFF;
        iReady    = 1'b1;
        expDirect = 8'b0010_0111;          // enabled bits of an all-ones input
        for (int s = 0; s < NCH; s++) begin
            iSelect = SELW'(s);
            step();
            checkOut($sformatf("direct.sel%0d", s), expDirect[s], s, 1'b1);
        end

        // ---------------- 2: backpressure ----------------
        iSelect = 3'd5;
        step();
        checkOut("bp.capture", 1'b1, 5, 1'b1);
        iReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iSelect = (i == 0) ? 3'd3 : (i == 1) ? 3'd4 : 3'd6;
            step();
            checkOut($sformatf("bp.hold%0d", i), 1'b1, 5, 1'b1);
        end
        iReady = 1'b1;
        step();
        checkOut("bp.release", 1'b0, 6, 1'b1);

        // ---------------- 3: scan round-robin ----------------
        iData = 8'h25;                     // ch0=1 ch1=0 ch2=1 ch5=1
        iMode = 1'b1;
        step();                            // DIRECT -> SEEK, no load
        checkOut("scan.toSeek", 1'b0, 6, 1'b1);
        step();                            // SEEK -> SCAN, no load
        checkOut("scan.toScan", 1'b0, 6, 1'b1);
        scanSeq = '{0, 1, 2, 5, 0};
        for (int g = 0; g < 5; g++) begin
            for (int r = 0; r < DWELL; r++) begin
                step();
                checkOut($sformatf("scan.g%0d.r%0d", g, r),
                         iData[scanSeq[g]], scanSeq[g], 1'b1);
            end
        end

        // ---------------- 5: mask change and mode change mid-scan ----------------
        for (int r = 0; r < DWELL; r++) begin
            step();
            checkOut($sformatf("mask.ch1.r%0d", r), 1'b0, 1, 1'b1);
        end
        for (int r = 0; r < 2; r++) begin
            step();
            checkOut($sformatf("mask.ch2.r%0d", r), 1'b1, 2, 1'b1);
        end
        iEnMask = 8'h23;                   // drop channel 2 mid-dwell
        step();                            // SCAN -> SEEK, no load
        checkOut("mask.toSeek", 1'b1, 2, 1'b1);
        step();                            // SEEK -> SCAN at ch0, no load
        checkOut("mask.toScan", 1'b1, 2, 1'b1);
        for (int r = 0; r < DWELL; r++) begin
            step();
            checkOut($sformatf("mask.resume.r%0d", r), 1'b1, 0, 1'b1);
        end
        step();
        checkOut("mask.next", 1'b0, 1, 1'b1);
        iMode   = 1'b0;
        iSelect = 3'd5;
        step();                            // SCAN -> DIRECT, no load
        checkOut("mode.toDirect", 1'b0, 1, 1'b1);
        step();
        checkOut("mode.direct", 1'b1, 5, 1'b1);

        // ---------------- 4: empty mask, then single channel ----------------
        iMode   = 1'b1;
        iEnMask = 8'h00;
        iReady  = 1'b0;
        step();                            // DIRECT -> SEEK
        checkOut("empty.toSeek", 1'b1, 5, 1'b1);
        step();                            // held word survives in SEEK
        checkOut("empty.held", 1'b1, 5, 1'b1);
        iReady = 1'b1;
        step();                            // held word accepted -> valid drops
        checkOut("empty.drain", 1'b1, 5, 1'b0);
        step();
        checkOut("empty.idle", 1'b1, 5, 1'b0);
        iEnMask = 8'h80;
        iData   = 8'hA5;
        step();                            // SEEK finds ch7 -> SCAN, no load
        checkOut("single.toScan", 1'b1, 5, 1'b0);
        for (int r = 0; r < 6; r++) begin
            step();
            checkOut($sformatf("single.r%0d", r), 1'b1, 7, 1'b1);
        end

        // ---------------- 6: async reset mid-stream ----------------
        iReady = 1'b0;
        step();
        checkOut("rst.pre", 1'b1, 7, 1'b1);
        #2;
        iRst_n = 1'b0;
        #1;
        checkOut("rst.async", 1'b0, 0, 1'b0);
        step();
        checkOut("rst.held", 1'b0, 0, 1'b0);
        iRst_n  = 1'b1;
        iMode   = 1'b0;
        iSelect = 3'd2;
        iReady  = 1'b1;
        iEnMask = 8'h27;
        step();                            // DIRECT after reset: loads at once
        checkOut("rst.direct", 1'b1, 2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
